irq_sequencer: RTL and testbench

- Collects interrupt requests from peripherals (timer, UART RX/TX, external pin), holds them as pending bits, and picks one by fixed priority.
- Drives the single IRQ input of the pipeline instruction-decode control unit and holds it until the pipeline acknowledges taking the interrupt.
- Tracks kernel entry and exit through PC[31], so only one interrupt is in service at a time and user code makes forward progress between interrupts.

---
 rtl/irq_sequencer.sv | 131 +++++++++++++
 tb/tb_irq_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: captures peripheral request edges into pending bits, picks one by
// fixed priority and hands it to the ID-stage control unit, one interrupt in service at a time.
module irq_sequencer #(
    parameter int N_SRC     = 4,
    parameter int CAUSE_W   = 2,
    parameter int GUARD_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   irq_src_i,
    input  logic [N_SRC-1:0]   irq_mask_i,
    input  logic [N_SRC-1:0]   clr_pend_i,
    input  logic               pc_31_i,
    input  logic               irq_ack_i,
    output logic               irq_o,
    output logic [CAUSE_W-1:0] irq_cause_o,
    output logic [N_SRC-1:0]   pending_o,
    output logic               in_service_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ENTER,
        KERNEL,
        GUARD
    } state_t;

    state_t             state_q;
    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   pending_q;
    logic [N_SRC-1:0]   pending_d;
    logic [3:0]         guard_q;
    logic               irq_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               in_service_q;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   ack_clr;
    logic [CAUSE_W-1:0] winner;
    logic               ack_take;

    assign rise     = irq_src_i & ~src_q;
    assign eligible = pending_q & irq_mask_i;
    assign ack_take = (state_q == REQ) && irq_ack_i;
    assign ack_clr  = ack_take ? (N_SRC'(1) << cause_q) : '0;

    // A new edge wins over any clear in the same cycle so no event is dropped.
    assign pending_d = (pending_q & ~clr_pend_i & ~ack_clr) | rise;

    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= irq_src_i;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            cause_q      <= '0;
            in_service_q <= 1'b0;
            guard_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((eligible != '0) && !pc_31_i) begin
                        cause_q <= winner;
                        irq_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= ENTER;
                    end else if (pc_31_i || !eligible[cause_q]) begin
                        // An exception got into kernel first, or the source went away.
                        irq_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ENTER: begin
                    if (pc_31_i) begin
                        state_q <= KERNEL;
                    end
                end
                KERNEL: begin
                    if (!pc_31_i) begin
                        guard_q      <= 4'(GUARD_CYC);
                        in_service_q <= 1'b0;
                        state_q      <= GUARD;
                    end
                end
                GUARD: begin
                    // Only user-mode cycles count toward forward progress.
                    if (guard_q == 4'd0) begin
                        state_q <= IDLE;
                    end else if (!pc_31_i) begin
                        guard_q <= guard_q - 4'd1;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_o        = irq_q;
    assign irq_cause_o  = cause_q;
    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: expected causes go into a queue, a monitor pops one on
// every IRQ rising edge; state and pending bits are checked directly after each edge.
module tb_irq_sequencer;

    localparam int N_SRC   = 4;
    localparam int CAUSE_W = 2;

    logic               clk;
    logic               rst_n;
    logic [N_SRC-1:0]   irq_src_i;
    logic [N_SRC-1:0]   irq_mask_i;
    logic [N_SRC-1:0]   clr_pend_i;
    logic               pc_31_i;
    logic               irq_ack_i;
    logic               irq_o;
    logic [CAUSE_W-1:0] irq_cause_o;
    logic [N_SRC-1:0]   pending_o;
    logic               in_service_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic irq_prev = 1'b0;

    irq_sequencer #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W), .GUARD_CYC(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src_i    (irq_src_i),
        .irq_mask_i   (irq_mask_i),
        .clr_pend_i   (clr_pend_i),
        .pc_31_i      (pc_31_i),
        .irq_ack_i    (irq_ack_i),
        .irq_o        (irq_o),
        .irq_cause_o  (irq_cause_o),
        .pending_o    (pending_o),
        .in_service_o (in_service_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_irq(input string name, input int bound);
        int n = 0;
        while (!irq_o && n < bound) begin
            step(1);
            n++;
        end
        check(name, 32'(irq_o), 32'd1);
    endtask

    // Monitor: every new IRQ assertion must match the oldest expected cause.
    always @(negedge clk) begin
        if (irq_o && !irq_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected_irq: got cause %0d expected no IRQ at %0t",
                         irq_cause_o, $time);
            end else begin
                check("mon_cause", 32'(irq_cause_o), 32'(exp_q.pop_front()));
            end
        end
        irq_prev = irq_o;
    end

    initial begin
        rst_n      = 1'b0;
        irq_src_i  = '0;
        irq_mask_i = 4'b1111;
        clr_pend_i = '0;
        pc_31_i    = 1'b0;
        irq_ack_i  = 1'b0;
        step(2);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_cause", 32'(irq_cause_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_in_service", 32'(in_service_o), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single event on source 2
        irq_src_i = 4'b0100;
        exp_q.push_back(2);
        step(1);
        check("t1_pending", 32'(pending_o), 32'h4);
        check("t1_irq_not_yet", 32'(irq_o), 32'd0);
        step(1);
        check("t1_irq", 32'(irq_o), 32'd1);
        check("t1_cause", 32'(irq_cause_o), 32'd2);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t1_hold", {30'd0, irq_o, irq_cause_o == 2'd2}, 32'd3);
        end
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        check("t1_ack_pending", 32'(pending_o), 32'h0);
        check("t1_ack_in_service", 32'(in_service_o), 32'd1);
        pc_31_i = 1'b1;
        step(3);
        pc_31_i = 1'b0;
        step(1);
        check("t1_exit_in_service", 32'(in_service_o), 32'd0);
        step(4);

        // Priority: sources 1 and 3 together
        irq_src_i = 4'b1010;
        exp_q.push_back(1);
        step(2);
        check("t2_irq", 32'(irq_o), 32'd1);
        check("t2_cause", 32'(irq_cause_o), 32'd1);
        irq_ack_i = 1'b1;
        exp_q.push_back(3);
        step(1);
        irq_ack_i = 1'b0;
        check("t2_ack_pending", 32'(pending_o), 32'h8);
        check("t2_ack_irq", 32'(irq_o), 32'd0);
        pc_31_i = 1'b1;
        step(6);
        check("t2_kernel_in_service", 32'(in_service_o), 32'd1);
        check("t2_kernel_irq", 32'(irq_o), 32'd0);
        pc_31_i = 1'b0;
        step(4);
        check("t2_guard_irq_low", 32'(irq_o), 32'd0);
        step(1);
        check("t2_after_guard_irq", 32'(irq_o), 32'd1);
        check("t2_after_guard_cause", 32'(irq_cause_o), 32'd3);

        // Set/clear collision on source 3 during ack
        irq_src_i = 4'b0010;
        step(1);
        irq_src_i = 4'b1010;
        irq_ack_i = 1'b1;
        exp_q.push_back(3);
        step(1);
        irq_ack_i = 1'b0;
        check("t3_collision_pending", 32'(pending_o), 32'h8);
        check("t3_in_service", 32'(in_service_o), 32'd1);
        pc_31_i = 1'b1;
        step(2);
        pc_31_i = 1'b0;
        wait_irq("t3_reservice", 8);
        check("t3_cause", 32'(irq_cause_o), 32'd3);

        // Withdraw by masking, then re-request
        irq_mask_i = 4'b0111;
        step(1);
        check("t4_withdraw_irq", 32'(irq_o), 32'd0);
        check("t4_withdraw_pending", 32'(pending_o), 32'h8);
        irq_mask_i = 4'b1111;
        exp_q.push_back(3);
        step(1);
        check("t4_rerequest_irq", 32'(irq_o), 32'd1);
        check("t4_rerequest_cause", 32'(irq_cause_o), 32'd3);
        clr_pend_i = 4'b1000;
        step(1);
        clr_pend_i = '0;
        step(1);
        check("t4_clear_irq", 32'(irq_o), 32'd0);
        check("t4_clear_pending", 32'(pending_o), 32'h0);

        // Kernel mode blocks a new request
        pc_31_i   = 1'b1;
        irq_src_i = 4'b1011;
        step(1);
        check("t5_pending", 32'(pending_o), 32'h1);
        step(8);
        check("t5_blocked_irq", 32'(irq_o), 32'd0);
        exp_q.push_back(0);
        pc_31_i = 1'b0;
        wait_irq("t5_release", 2);
        check("t5_cause", 32'(irq_cause_o), 32'd0);
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        pc_31_i = 1'b1;
        step(2);
        irq_src_i = 4'b1001;
        step(1);
        irq_src_i = 4'b1011;
        step(1);
        check("t6_kernel_in_service", 32'(in_service_o), 32'd1);
        check("t6_kernel_pending", 32'(pending_o), 32'h2);

        // Asynchronous reset between clock edges
        #2;
        rst_n     = 1'b0;
        irq_src_i = 4'b0001;
        pc_31_i   = 1'b0;
        #1;
        check("t6_async_irq", 32'(irq_o), 32'd0);
        check("t6_async_pending", 32'(pending_o), 32'h0);
        check("t6_async_in_service", 32'(in_service_o), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_q.push_back(0);
        step(1);
        check("t6_release_pending", 32'(pending_o), 32'h1);
        check("t6_release_irq_low", 32'(irq_o), 32'd0);
        step(1);
        check("t6_release_irq", 32'(irq_o), 32'd1);
        check("t6_release_cause", 32'(irq_cause_o), 32'd0);
        step(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
